// File: rtl/crc_2_level_pipeline.sv
// Purpose: 2-bit-per-clock LFSR CRC for 10-bit words, G(x) = x^9 + POLY, remainder M(x)*x^9 mod G(x).
// Latency: a word sampled on a frame-start edge appears on data_out one frame (5 clocks) later and holds for 5 clocks.
// Backpressure: none; free-running, one word taken every 5 clocks, data_in ignored off the frame-start edge.
module crc_2_level_pipeline #(
    parameter logic [8:0] POLY = 9'b100000011
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [9:0] data_in,
    output logic [8:0] data_out
);

    logic [2:0] cnt;
    logic [7:0] msg;
    logic [8:0] crc;

    logic       frame_start;
    logic [8:0] crc_nxt;
    logic [7:0] msg_nxt;
    logic [2:0] cnt_nxt;

    // One serial LFSR step: shift one message bit in, MSB first.
    function automatic logic [8:0] step(input logic [8:0] c, input logic b);
        logic fb;
        fb = c[8] ^ b;
        return {c[7:0], 1'b0} ^ (fb ? POLY : 9'b0);
    endfunction

    // Two serial steps collapsed into a single combinational XOR network.
    function automatic logic [8:0] step2(input logic [8:0] c, input logic b1, input logic b0);
        return step(step(c, b1), b0);
    endfunction

    // Out-of-range counter values 5..7 restart the frame so sequencing self-heals.
    assign frame_start = (cnt == 3'd0) || (cnt > 3'd4);

    // Level-1 next state: seed from the new word at frame start, otherwise consume two message bits.
    always_comb begin
        crc_nxt = crc;
        msg_nxt = msg;
        cnt_nxt = cnt;
        if (frame_start) begin
            crc_nxt = step2(9'b0, data_in[9], data_in[8]);
            msg_nxt = data_in[7:0];
            cnt_nxt = 3'd1;
        end else begin
            crc_nxt = step2(crc, msg[7], msg[6]);
            msg_nxt = {msg[5:0], 2'b00};
            cnt_nxt = (cnt == 3'd4) ? 3'd0 : cnt + 3'd1;
        end
    end

    // Level-1 LFSR state and frame counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= 3'd0;
            msg <= 8'd0;
            crc <= 9'd0;
        end else begin
            cnt <= cnt_nxt;
            msg <= msg_nxt;
            crc <= crc_nxt;
        end
    end

    // Level-2 result register: capture the finished remainder as the next frame begins.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_out <= 9'd0;
        end else if (frame_start) begin
            data_out <= crc;
        end
    end

endmodule

// File: tb/tb_crc_2_level_pipeline.sv
// Purpose: randomized self-checking bench for crc_2_level_pipeline against a polynomial-division model.
// Latency: model expects each sampled word's remainder on data_out one frame after it is sampled.
// Backpressure: none; stimulus drives one value per clock on the falling edge.
module tb_crc_2_level_pipeline;

    logic       clk;
    logic       reset;
    logic [9:0] data_in;
    logic [8:0] data_out;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: position within the frame and the word awaiting its result.
    int         pos;
    logic       prev_valid;
    logic [9:0] prev_word;
    logic [8:0] exp_out;

    crc_2_level_pipeline dut (
        .clk      (clk),
        .reset    (reset),
        .data_in  (data_in),
        .data_out (data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [8:0] got, input logic [8:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b", tag, got, exp);
        end
    endtask

    // Long division of M(x)*x^9 by G(x) over GF(2).
    function automatic logic [8:0] crc_ref(input logic [9:0] w);
        logic [18:0] r;
        logic [18:0] g;
        r = {w, 9'b0};
        g = 19'b1100000011;
        for (int i = 18; i >= 9; i--) begin
            if (r[i]) r = r ^ (g << (i - 9));
        end
        return r[8:0];
    endfunction

    task automatic model_reset();
        pos        = 0;
        prev_valid = 1'b0;
        prev_word  = 10'd0;
        exp_out    = 9'd0;
    endtask

    // Drive one value on the falling edge, clock once, update the model, check on the next falling edge.
    task automatic tick(input logic [9:0] d, input string tag);
        data_in = d;
        @(posedge clk);
        if (reset) begin
            if (pos == 0) begin
                exp_out    = prev_valid ? crc_ref(prev_word) : 9'd0;
                prev_word  = d;
                prev_valid = 1'b1;
            end
            pos = (pos + 1) % 5;
        end
        @(negedge clk);
        check(tag, data_out, exp_out);
    endtask

    // One whole frame: the word on the sampling edge, random junk on the other four.
    task automatic frame(input logic [9:0] w, input string tag);
        tick(w, tag);
        for (int i = 1; i < 5; i++) tick(10'($urandom), tag);
    endtask

    initial begin
        reset   = 1'b0;
        data_in = 10'd0;
        model_reset();
        @(negedge clk);

        // Reset held with arbitrary input.
        for (int i = 0; i < 4; i++) tick(10'($urandom), "reset_hold");

        reset = 1'b1;
        // Word equal to G gives a zero remainder in every frame.
        for (int i = 0; i < 3; i++) frame(10'b1100000011, "poly_word");
        frame(10'h001, "word_001");
        frame(10'h002, "word_002");
        frame(10'h003, "word_003");
        frame(10'h001, "b2b_001");
        frame(10'h002, "b2b_002");
        frame(10'h000, "drain");

        // Abort a frame at cnt==2 with an asynchronous reset between edges.
        tick(10'h155, "abort_frame");
        tick(10'($urandom), "abort_frame");
        #2 reset = 1'b0;
        #1 check("async_reset", data_out, 9'd0);
        model_reset();
        @(negedge clk);
        tick(10'($urandom), "abort_hold");
        tick(10'($urandom), "abort_hold");
        reset = 1'b1;
        frame(10'h001, "after_abort");
        frame(10'h001, "after_abort");
        frame(10'h000, "after_abort");

        // Random words with random junk between sampling edges.
        for (int f = 0; f < 20; f++) frame(10'($urandom), "random");

        $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
        $finish;
    end

endmodule
